// File: rtl/quadtree_local_injector_pkg.sv
// Shared router definitions for the LOCAL injection channel: field widths,
// port directions, and the flit packing helper.
package quadtree_local_injector_pkg;

  localparam int ROUTER_WIDTH      = 32;
  localparam int ROUTER_INFO_WIDTH = 4;
  localparam int ROUTER_ADDR_WIDTH = 8;
  localparam int PAYLOAD_WIDTH     = ROUTER_WIDTH - ROUTER_INFO_WIDTH - ROUTER_ADDR_WIDTH;
  localparam int LOCAL_BUF_DEPTH   = 2;

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_NW    = 3'd1,
    DIR_NE    = 3'd2,
    DIR_SW    = 3'd3,
    DIR_SE    = 3'd4,
    DIR_UP    = 3'd5
  } dir_e;

  typedef logic [ROUTER_WIDTH-1:0]      flit_t;
  typedef logic [ROUTER_INFO_WIDTH-1:0] info_t;
  typedef logic [ROUTER_ADDR_WIDTH-1:0] addr_t;
  typedef logic [PAYLOAD_WIDTH-1:0]     payload_t;

  // Info sits in the MSBs so the router can decode it without knowing the payload size.
  function automatic flit_t pack_flit(input info_t info, input addr_t addr,
                                      input payload_t payload);
    return {info, addr, payload};
  endfunction

endpackage

// File: rtl/quadtree_local_injector_if.sv
// PE request channel plus router LOCAL data/credit channel of the injector.
interface quadtree_local_injector_if;
  import quadtree_local_injector_pkg::*;

  logic     pe_valid;
  logic     pe_ready;
  info_t    pe_info;
  addr_t    pe_addr;
  payload_t pe_payload;
  logic     out_data_valid;
  flit_t    out_data;
  logic     in_credit;

  // master: the PE/router environment around the injector
  modport master (
    output pe_valid, pe_info, pe_addr, pe_payload, in_credit,
    input  pe_ready, out_data_valid, out_data
  );

  modport slave (
    input  pe_valid, pe_info, pe_addr, pe_payload, in_credit,
    output pe_ready, out_data_valid, out_data
  );

endinterface

// File: rtl/quadtree_local_injector_flit_fifo.sv
// Synchronous flit FIFO with wrap-bit pointers; head is read combinationally.
module flit_fifo
  import quadtree_local_injector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ROUTER_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/quadtree_local_injector.sv
// Credit-based source for the router LOCAL input: buffers PE requests as
// single-flit packets and injects them only while a downstream credit is held.
module quadtree_local_injector
  import quadtree_local_injector_pkg::*;
#(
  parameter int  FIFO_DEPTH   = 4,
  parameter int  CREDIT_DEPTH = LOCAL_BUF_DEPTH,
  localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  quadtree_local_injector_if.slave  bus,
  output logic [CNT_W-1:0]          credit_cnt,
  output logic                      credit_err,
  output logic                      idle
);

  localparam int               AW         = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);

  flit_t       req_flit;
  flit_t       fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        push;
  logic        send;

  assign req_flit     = pack_flit(bus.pe_info, bus.pe_addr, bus.pe_payload);
  assign bus.pe_ready = !fifo_full;
  assign push         = bus.pe_valid && !fifo_full;
  assign send         = !fifo_empty && (credit_cnt != '0);

  flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROUTER_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (req_flit),
    .pop   (send),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Output register: valid for exactly the cycle after a send; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data_valid <= 1'b0;
      bus.out_data       <= '0;
    end else begin
      bus.out_data_valid <= send;
      if (send) bus.out_data <= fifo_head;
    end
  end

  // Credit counter: a send and a return in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      unique case ({send, bus.in_credit})
        2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01: begin
          if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
          else                          credit_cnt <= credit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign idle = (fifo_count == '0) && (credit_cnt == CREDIT_MAX) && !bus.out_data_valid;

endmodule

// File: tb/tb_quadtree_local_injector.sv
// Bench for quadtree_local_injector: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_quadtree_local_injector;
  import quadtree_local_injector_pkg::*;

  localparam int FIFO_DEPTH   = 4;
  localparam int CREDIT_DEPTH = LOCAL_BUF_DEPTH;
  localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_err;
  logic             idle;

  quadtree_local_injector_if bus();

  quadtree_local_injector #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CREDIT_DEPTH (CREDIT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  flit_t mq[$];
  int    m_cred;
  bit    m_err;
  bit    m_valid;
  flit_t m_data;

  typedef struct {
    bit       v;
    info_t    info;
    addr_t    addr;
    payload_t pl;
    bit       cr;
    bit       e_valid;
    flit_t    e_data;
    int       e_cnt;
    bit       e_ready;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cred  = CREDIT_DEPTH;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic drive(input bit v, input info_t info, input addr_t addr,
                       input payload_t pl, input bit cr);
    bus.pe_valid   = v;
    bus.pe_info    = info;
    bus.pe_addr    = addr;
    bus.pe_payload = pl;
    bus.in_credit  = cr;
  endtask

  // One clock: predict from the current inputs, advance, then compare every output.
  task automatic tick();
    bit    snd;
    bit    acc;
    bit    cr;
    flit_t req;
    check("pe_ready", 32'(bus.pe_ready), 32'(mq.size() < FIFO_DEPTH));
    snd = (mq.size() > 0) && (m_cred > 0);
    acc = bus.pe_valid && (mq.size() < FIFO_DEPTH);
    cr  = bus.in_credit;
    req = {bus.pe_info, bus.pe_addr, bus.pe_payload};
    @(posedge clk);
    #1;
    m_valid = snd;
    if (snd) m_data = mq.pop_front();
    if (acc) mq.push_back(req);
    m_cred = m_cred - int'(snd) + int'(cr);
    if (m_cred > CREDIT_DEPTH) begin
      m_cred = CREDIT_DEPTH;
      m_err  = 1'b1;
    end
    check("out_data_valid", 32'(bus.out_data_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("credit_cnt", 32'(credit_cnt), 32'(m_cred));
    check("credit_err", 32'(credit_err), 32'(m_err));
    check("idle", 32'(idle), 32'((mq.size() == 0) && (m_cred == CREDIT_DEPTH) && !m_valid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev;

    tbl[0]  = '{1'b1, 4'h1, 8'h03, 20'h000A5, 1'b0, 1'b0, 32'h00000000, 2, 1'b1};
    tbl[1]  = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b0, 1'b1, 32'h103000A5, 1, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b0, 1'b0, 32'h103000A5, 1, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b1, 1'b0, 32'h103000A5, 2, 1'b1};
    tbl[4]  = '{1'b1, 4'h2, 8'h11, 20'h00001, 1'b0, 1'b0, 32'h103000A5, 2, 1'b1};
    tbl[5]  = '{1'b1, 4'h2, 8'h12, 20'h00002, 1'b0, 1'b1, 32'h21100001, 1, 1'b1};
    tbl[6]  = '{1'b1, 4'h2, 8'h13, 20'h00003, 1'b0, 1'b1, 32'h21200002, 0, 1'b1};
    tbl[7]  = '{1'b1, 4'h2, 8'h14, 20'h00004, 1'b0, 1'b0, 32'h21200002, 0, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b0, 1'b0, 32'h21200002, 0, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b1, 1'b0, 32'h21200002, 1, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b0, 1'b1, 32'h21300003, 0, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b1, 1'b0, 32'h21300003, 1, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b0, 1'b1, 32'h21400004, 0, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b1, 1'b0, 32'h21400004, 1, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 8'h00, 20'h00000, 1'b1, 1'b0, 32'h21400004, 2, 1'b1};

    // Reset state
    drive(1'b0, '0, '0, '0, 1'b0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_data_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_cnt", 32'(credit_cnt), 32'(CREDIT_DEPTH));
    check("rst_err", 32'(credit_err), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(bus.pe_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single flit latency, then credit exhaustion and return
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].info, tbl[i].addr, tbl[i].pl, tbl[i].cr);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.out_data_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
      check($sformatf("vec%0d_cnt", i), 32'(credit_cnt), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_ready", i), 32'(bus.pe_ready), 32'(tbl[i].e_ready));
    end

    // Full FIFO: spend both credits, then fill with none left
    drive(1'b1, 4'h3, 8'h21, 20'h00011, 1'b0); tick();
    drive(1'b1, 4'h3, 8'h22, 20'h00012, 1'b0); tick();
    drive(1'b0, '0, '0, '0, 1'b0); tick(); tick();
    check("t3_cnt0", 32'(credit_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'h4, 8'(48 + k), 20'(k + 1), 1'b0);
      tick();
    end
    check("t3_full_ready", 32'(bus.pe_ready), 32'd0);
    drive(1'b1, 4'h4, 8'h35, 20'h00005, 1'b0); tick();
    check("t3_stall_ready", 32'(bus.pe_ready), 32'd0);
    drive(1'b1, 4'h4, 8'h35, 20'h00005, 1'b1); tick();
    check("t3_credit_ready", 32'(bus.pe_ready), 32'd0);
    drive(1'b1, 4'h4, 8'h35, 20'h00005, 1'b0); tick();
    check("t3_pop_valid", 32'(bus.out_data_valid), 32'd1);
    check("t3_pop_ready", 32'(bus.pe_ready), 32'd1);
    tick();
    check("t3_refill_ready", 32'(bus.pe_ready), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b1); tick();
    drive(1'b0, '0, '0, '0, 1'b0); tick();
    check("t6_pre_cnt", 32'(credit_cnt), 32'd0);

    // Asynchronous reset with three flits queued and no credits
    #2;
    rst = 1'b1;
    #2;
    check("t6_valid", 32'(bus.out_data_valid), 32'd0);
    check("t6_cnt", 32'(credit_cnt), 32'(CREDIT_DEPTH));
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_ready", 32'(bus.pe_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_stale", 32'(bus.out_data_valid), 32'd0);

    // Streaming with every flit's credit echoed back one cycle later
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'h5, 8'(i), 20'(i * 3 + 7), prev);
      tick();
      if (i >= 2) begin
        check("t4_stream_valid", 32'(bus.out_data_valid), 32'd1);
        check("t4_stream_cnt", 32'(credit_cnt), 32'd1);
      end
      prev = bus.out_data_valid;
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, '0, prev);
      tick();
      prev = bus.out_data_valid;
    end
    check("t4_idle", 32'(idle), 32'd1);

    // Randomized traffic; the router only returns credits it owes
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), info_t'($urandom), addr_t'($urandom),
            payload_t'($urandom), (m_cred < CREDIT_DEPTH) && ($urandom_range(0, 2) == 0));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, '0, '0, '0, (m_cred < CREDIT_DEPTH));
      tick();
    end
    check("rand_drain_idle", 32'(idle), 32'd1);

    // Spurious credit while full
    check("t5_err_before", 32'(credit_err), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b1); tick();
    check("t5_err_set", 32'(credit_err), 32'd1);
    check("t5_cnt_sat", 32'(credit_cnt), 32'(CREDIT_DEPTH));
    drive(1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_err_sticky", 32'(credit_err), 32'd1);
    #2;
    rst = 1'b1;
    #2;
    check("t5_err_cleared", 32'(credit_err), 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quadtree_local_injector.md
Name: quadtree_local_injector

Overview:
Source end of the router's credit-based LOCAL input channel. It sits between a processing element (PE) and the quadtree router's LOCAL input port.
- Accepts {route_info, route_addr, payload} requests from the PE on a valid/ready handshake.
- Packs each request into a single-flit packet and buffers it.
- Injects flits into the router only when a downstream credit is held.
- Reclaims credits from the router's LOCAL in_credit pulse.

Parameters:
FIFO_DEPTH, 4, injection buffer entries (power of 2, >=2)
CREDIT_DEPTH, 2, initial credit count; equals LOCAL input-buffer depth of the attached router
CNT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  system reset (active high)
pe_valid  in  1  PE request valid
pe_ready  out  1  injector can accept request
pe_info  in  ROUTER_INFO_WIDTH  routing info field
pe_addr  in  ROUTER_ADDR_WIDTH  routing address field
pe_payload  in  PAYLOAD_WIDTH  payload (ROUTER_WIDTH-INFO-ADDR)
out_data_valid  out  1  flit valid to router LOCAL in_data_valid
out_data  out  ROUTER_WIDTH  flit to router LOCAL in_data
in_credit  in  1  credit return pulse from router LOCAL in_credit
credit_cnt  out  CNT_W  current credits held
credit_err  out  1  sticky: credit returned while counter full
idle  out  1  FIFO empty, credits full, no flit in flight on output

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: out_data_valid=0, out_data=0, credit_cnt=CREDIT_DEPTH, credit_err=0, FIFO empty, pe_ready=1, idle=1.
- Flit format: out_data = {info, addr, payload}, MSB first. info occupies the top ROUTER_INFO_WIDTH bits.
- Accept: a request is taken on a rising edge when pe_valid & pe_ready. pe_ready = !fifo_full, combinational from the FIFO count only. pe_ready has no dependence on pe_valid.
- Send condition, evaluated each cycle: send = !fifo_empty & (credit_cnt != 0). On the edge when send is true:
  - pop the FIFO head into the out_data register;
  - set out_data_valid=1 for exactly that next cycle.
  When send is false, out_data_valid=0 and out_data holds its previous value.
- Throughput/latency:
  - At most one flit per cycle.
  - Minimum latency from accept edge N to out_data_valid high is the cycle after edge N+1 (2 cycles). There is no FIFO bypass.
  - Back-to-back flits are sent while credits last.
- Credit counter:
  - next = cnt - send + in_credit.
  - Simultaneous send and in_credit leaves the count unchanged.
  - send never occurs at cnt=0, so the counter cannot underflow.
  - If in_credit arrives while cnt==CREDIT_DEPTH and send=0, the counter saturates at CREDIT_DEPTH and credit_err sets. credit_err holds until rst.
- FIFO:
  - Push and pop in the same cycle are allowed when full: pop frees the entry, but pe_ready is still 0 that cycle, so no push occurs.
  - Push and pop in the same cycle are allowed when non-empty: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.
- idle = fifo_empty & (credit_cnt==CREDIT_DEPTH) & !out_data_valid.
- Reset asserted mid-operation: FIFO contents are discarded, credits return to CREDIT_DEPTH, and any in-flight output is dropped. The attached router resets on the same rst.

Decomposition:
- Shared package router.vh:
  - existing ROUTER_WIDTH, ROUTER_INFO_WIDTH, ROUTER_ADDR_WIDTH, DIR_LOCAL;
  - add `PAYLOAD_WIDTH (= ROUTER_WIDTH - ROUTER_INFO_WIDTH - ROUTER_ADDR_WIDTH);
  - add `LOCAL_BUF_DEPTH as the default for CREDIT_DEPTH.
- One sub-module: flit_fifo. Synchronous FIFO with parameter DEPTH and WIDTH=ROUTER_WIDTH, providing push, pop, full, empty, head data and count.
- Credit counter and output register stay in the top module.

Test Plan:
1. Reset, then a single request (info=1, addr=3, payload=0xA5) -> out_data_valid is high exactly one cycle, 2 cycles after accept; out_data={1,3,0xA5}; credit_cnt goes 2->1.
2. Push 4 requests with in_credit held 0 -> exactly 2 flits sent, credit_cnt=0, 2 flits remain in the FIFO and pe_ready=1. Then pulse in_credit twice -> the remaining 2 flits are sent in order, one per credit.
3. Fill the FIFO (5 pushes attempted with credit 0) -> pe_ready=0 after the 4th accept and the 5th request stalls. One credit return -> one pop, then pe_ready=1 on the following cycle.
4. Steady streaming with in_credit pulsed every cycle, one cycle after each flit -> after initial fill, out_data_valid is high continuously and credit_cnt is stable at 1 (simultaneous send and credit).
5. in_credit pulse while idle with credit_cnt=2 -> credit_cnt stays 2, credit_err=1 and stays 1 until rst.
6. Assert rst with 3 flits queued and credit_cnt=0 -> immediately out_data_valid=0, credit_cnt=2, idle=1, pe_ready=1; no stale flit is emitted after reset release.
